// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS link: word layout, field positions and
// the alignment bytes used by the TX framer and the RX deframer.
package lvds_link_pkg;

  localparam int LINK_WORD_W = 32;
  localparam int VALID_BIT   = 31;
  localparam int ID_LSB      = 29;
  localparam int ID_W        = 2;
  localparam int PAYLOAD_W   = LINK_WORD_W - 1 - ID_W;

  localparam logic [7:0] TRAIN_BYTE = 8'h35;
  localparam logic [7:0] SYNC_BYTE  = 8'h77;

  // Occupancy of the single output holding register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// the pointer, searched cyclically. Grant is one-hot and only when enabled.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // One extra bit so ptr + offset cannot overflow before the modulo wrap.
  localparam int SUM_W = IDX_W + 1;

  logic             found;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;

  // Walk the requests starting at the pointer and keep the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    grant = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (enable && found) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/lvds_tx_arbiter.sv
// Shares the 32-bit LVDS TX word channel among NUM_REQ clients. The winner's
// payload is tagged with a valid bit and its source ID and held in a single
// register until the TX framer dequeues it.
module lvds_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int PAYLOAD_W = 29,
  parameter int CNT_W     = 16
) (
  input  logic                         tx_inclock,
  input  logic                         reset,
  input  logic                         link_up,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [31:0]                  enq_tx,
  output logic                         RDY_enq_tx,
  input  logic                         EN_enq_tx,
  output logic [CNT_W-1:0]             words_sent,
  output logic [ID_W-1:0]              grant_id
);

  import lvds_link_pkg::*;

  tx_state_t              state;
  logic [LINK_WORD_W-1:0] word_q;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        grant_id_q;
  logic [CNT_W-1:0]       words_sent_q;

  logic                   rdy;
  logic                   deq;
  logic                   can_load;
  logic                   accept;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        win_idx;
  logic [PAYLOAD_W-1:0]   win_payload;

  // A dequeue only counts while the word is actually offered to the framer;
  // a new word may load into an empty register or the one just emptied.
  always_comb begin
    rdy      = (state == ST_FULL) && link_up;
    deq      = EN_enq_tx && rdy;
    can_load = link_up && ((state == ST_EMPTY) || deq);
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (can_load),
    .grant  (grant),
    .idx    (win_idx)
  );

  // Select the winning requester's payload from the packed data bus.
  always_comb begin
    accept      = |grant;
    win_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_payload = req_data[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Holding-register FSM: load on accept, drain on dequeue, count sent words.
  always_ff @(posedge tx_inclock) begin
    if (reset) begin
      state        <= ST_EMPTY;
      word_q       <= '0;
      ptr_q        <= '0;
      grant_id_q   <= '0;
      words_sent_q <= '0;
    end else begin
      if (deq) begin
        words_sent_q <= words_sent_q + 1'b1;
      end
      if (accept) begin
        state      <= ST_FULL;
        word_q     <= {1'b1, win_idx, win_payload};
        grant_id_q <= win_idx;
        if (win_idx == ID_W'(NUM_REQ - 1)) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= win_idx + 1'b1;
        end
      end else if (deq) begin
        state  <= ST_EMPTY;
        word_q <= '0;
      end
    end
  end

  assign req_ready  = grant;
  assign enq_tx     = word_q;
  assign RDY_enq_tx = rdy;
  assign words_sent = words_sent_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// Directed bench for lvds_tx_arbiter with hand-computed expectations.
module tb_lvds_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int PAYLOAD_W = 29;
  localparam int CNT_W     = 16;

  logic                         tx_inclock = 1'b0;
  logic                         reset;
  logic                         link_up;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*PAYLOAD_W-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [31:0]                  enq_tx;
  logic                         RDY_enq_tx;
  logic                         EN_enq_tx;
  logic [CNT_W-1:0]             words_sent;
  logic [ID_W-1:0]              grant_id;

  int total = 0;
  int bad   = 0;

  lvds_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ID_W      (ID_W),
    .PAYLOAD_W (PAYLOAD_W),
    .CNT_W     (CNT_W)
  ) dut (
    .tx_inclock (tx_inclock),
    .reset      (reset),
    .link_up    (link_up),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .enq_tx     (enq_tx),
    .RDY_enq_tx (RDY_enq_tx),
    .EN_enq_tx  (EN_enq_tx),
    .words_sent (words_sent),
    .grant_id   (grant_id)
  );

  // Free-running 10 ns clock.
  always #5 tx_inclock = ~tx_inclock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic lu, input logic [NUM_REQ-1:0] rv, input logic en);
    link_up   = lu;
    req_valid = rv;
    EN_enq_tx = en;
  endtask

  task automatic tick();
    @(posedge tx_inclock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] exp_word;

  initial begin
    reset    = 1'b1;
    req_data = '0;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*PAYLOAD_W +: PAYLOAD_W] = PAYLOAD_W'(32'h100 + i);
    end

    // Test 1: reset state, single word from requester 0
    tick();
    tick();
    checkOutput("rst_enq_tx", enq_tx, 32'h0);
    checkOutput("rst_rdy", {31'b0, RDY_enq_tx}, 32'h0);
    checkOutput("rst_words", {16'b0, words_sent}, 32'h0);
    checkOutput("rst_grant_id", {30'b0, grant_id}, 32'h0);
    checkOutput("rst_ready", {28'b0, req_ready}, 32'h0);
    reset = 1'b0;
    req_data[0 +: PAYLOAD_W] = 29'h0ABCDEF;
    applyStimulus(1'b1, 4'b0001, 1'b0);
    settle();
    checkOutput("t1_ready", {28'b0, req_ready}, 32'h1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t1_rdy", {31'b0, RDY_enq_tx}, 32'h1);
    checkOutput("t1_word", enq_tx, 32'h80ABCDEF);
    checkOutput("t1_grant_id", {30'b0, grant_id}, 32'h0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t1_words", {16'b0, words_sent}, 32'h1);
    checkOutput("t1_rdy_after", {31'b0, RDY_enq_tx}, 32'h0);
    checkOutput("t1_word_after", enq_tx, 32'h0);

    // Test 2: all requesters valid, framer dequeues every 4th cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_data[0 +: PAYLOAD_W] = 29'h100;
    applyStimulus(1'b1, 4'b1111, 1'b0);
    tick();
    for (int n = 0; n < 6; n++) begin
      exp_word = {1'b1, 2'(n % 4), 29'(32'h100 + (n % 4))};
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("t2_rdy_w%0d_c%0d", n, c), {31'b0, RDY_enq_tx}, 32'h1);
        checkOutput($sformatf("t2_word_w%0d_c%0d", n, c), enq_tx, exp_word);
        applyStimulus(1'b1, 4'b1111, (c == 3));
        tick();
      end
    end
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("t2_words", {16'b0, words_sent}, 32'd6);
    checkOutput("t2_next_id", {30'b0, enq_tx[30:29]}, 32'd2);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t2_drain_words", {16'b0, words_sent}, 32'd7);
    checkOutput("t2_drain_rdy", {31'b0, RDY_enq_tx}, 32'h0);

    // Test 3: link down blocks accepts; requester 2 wins once link returns
    req_data[2*PAYLOAD_W +: PAYLOAD_W] = 29'h1234567;
    applyStimulus(1'b0, 4'b0100, 1'b0);
    settle();
    checkOutput("t3_ready_down", {28'b0, req_ready}, 32'h0);
    checkOutput("t3_rdy_down", {31'b0, RDY_enq_tx}, 32'h0);
    tick();
    checkOutput("t3_word_down", enq_tx, 32'h0);
    applyStimulus(1'b1, 4'b0100, 1'b0);
    settle();
    checkOutput("t3_ready_up", {28'b0, req_ready}, 32'h4);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t3_id", {30'b0, enq_tx[30:29]}, 32'd2);
    checkOutput("t3_word", enq_tx, 32'hC1234567);
    checkOutput("t3_grant_id", {30'b0, grant_id}, 32'd2);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t3_words", {16'b0, words_sent}, 32'd8);

    // Test 4: dequeue ignored while link is down, word retained
    req_data[1*PAYLOAD_W +: PAYLOAD_W] = 29'h55;
    applyStimulus(1'b1, 4'b0010, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t4_word", enq_tx, 32'hA0000055);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    settle();
    checkOutput("t4_rdy_down", {31'b0, RDY_enq_tx}, 32'h0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("t4_words_held", {16'b0, words_sent}, 32'd8);
    checkOutput("t4_rdy_held", {31'b0, RDY_enq_tx}, 32'h0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    settle();
    checkOutput("t4_rdy_back", {31'b0, RDY_enq_tx}, 32'h1);
    checkOutput("t4_word_back", enq_tx, 32'hA0000055);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t4_words", {16'b0, words_sent}, 32'd9);

    // Test 5: reset while a word is held discards it and rewinds the pointer
    applyStimulus(1'b1, 4'b1111, 1'b0);
    tick();
    checkOutput("t5_loaded_id", {30'b0, enq_tx[30:29]}, 32'd2);
    reset = 1'b1;
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    reset = 1'b0;
    checkOutput("t5_rdy", {31'b0, RDY_enq_tx}, 32'h0);
    checkOutput("t5_word", enq_tx, 32'h0);
    checkOutput("t5_words", {16'b0, words_sent}, 32'h0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    settle();
    checkOutput("t5_ready", {28'b0, req_ready}, 32'h1);
    tick();
    checkOutput("t5_grant_id", {30'b0, grant_id}, 32'h0);
    checkOutput("t5_word_id0", enq_tx, 32'h80000100);

    // Test 6: back-to-back traffic up to 16'hFFFF, then one more wraps to 0
    applyStimulus(1'b1, 4'b1111, 1'b1);
    for (int n = 0; n < 65535; n++) begin
      tick();
    end
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("t6_words_max", {16'b0, words_sent}, 32'h0000FFFF);
    checkOutput("t6_rdy", {31'b0, RDY_enq_tx}, 32'h1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("t6_words_wrap", {16'b0, words_sent}, 32'h0);
    checkOutput("t6_rdy_empty", {31'b0, RDY_enq_tx}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lvds_tx_arbiter.md
Name: lvds_tx_arbiter

Overview:
- Round-robin scheduler that shares the single 32-bit LVDS TX word channel between NUM_REQ client requesters.
- Tags each accepted word with a valid bit and a source ID, then holds it in one output register.
- Presents the held word to the link TX framer, which serializes it as 4 bytes and pulses a dequeue once per word slot.
- Sits between client logic and the TX framer in the tx_inclock domain.

Parameters:
- NUM_REQ, 4: number of requesters; must be 2..4.
- ID_W, 2: source-ID field width; must satisfy 2**ID_W >= NUM_REQ.
- PAYLOAD_W, 29: payload width; must equal 32-1-ID_W.
- CNT_W, 16: width of the sent-word counter.

Ports:
- tx_inclock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- link_up  in  1  link trained and aligned (TX align handshake complete).
- req_valid  in  NUM_REQ  requester i has a payload.
- req_data  in  NUM_REQ*PAYLOAD_W  requester i payload at [i*PAYLOAD_W +: PAYLOAD_W].
- req_ready  out  NUM_REQ  requester i payload accepted this cycle.
- enq_tx  out  32  held word to framer: [31]=1 valid, [30:29]=source ID, [28:0]=payload.
- RDY_enq_tx  out  1  held word available to framer.
- EN_enq_tx  in  1  framer consumed the word (one-cycle pulse).
- words_sent  out  CNT_W  count of words consumed by framer.
- grant_id  out  ID_W  ID of last accepted requester.

Behaviour:
- Reset values: all outputs 0; held register empty; round-robin pointer = 0.
- Reset applies on any cycle, including mid-operation. A held word is discarded, not sent.
- Two states:
  - EMPTY: no word held.
  - FULL: word held.
- can_load = link_up & (state==EMPTY | (state==FULL & EN_enq_tx & RDY_enq_tx)).
- Arbitration (combinational):
  - Among asserted req_valid, pick the first index at or after the pointer, cyclically.
  - req_ready is one-hot, and only for the winner, when can_load=1; otherwise all zero.
  - No requester's readiness depends on its own req_valid beyond the winner selection.
- On accept (req_ready[i]=1):
  - Next cycle: enq_tx = {1'b1, i[ID_W-1:0], payload_i}; state FULL.
  - grant_id = i; pointer = (i+1) mod NUM_REQ.
  - Latency from accept to RDY_enq_tx=1 is exactly 1 cycle.
- RDY_enq_tx = (state==FULL) & link_up.
- EN_enq_tx is ignored when RDY_enq_tx=0; no counter change, no state change.
- On EN_enq_tx with RDY_enq_tx=1:
  - words_sent increments, wrapping at 2**CNT_W.
  - If a new accept happens the same cycle, the register reloads and stays FULL (back-to-back, no bubble).
  - Otherwise state goes to EMPTY and enq_tx[31] is cleared (enq_tx = 0).
- While EMPTY, enq_tx = 0, so the framer's RDY gating leaves bit31=0 and the far RX discards the slot.
- link_up low:
  - No accepts.
  - RDY_enq_tx=0.
  - A held word is retained and presented again once link_up returns.
  - The pointer is frozen.
- The pointer advances only on an accept, never on idle cycles.
- Sustained rate is set by the framer, one word per 4 cycles. All NUM_REQ requesters held valid receive grants in strict rotation.

Decomposition:
- Package lvds_link_pkg holds:
  - LINK_WORD_W=32, VALID_BIT=31, ID_LSB=29, ID_W, PAYLOAD_W.
  - Training byte 8'h35 and sync byte 8'h77, shared with the framer and RX deframer.
- Sub-module rr_arbiter, parameterized by NUM_REQ:
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, binary index.
- All registers live in lvds_tx_arbiter.

Test Plan:
1. Reset, link_up=1, req_valid=4'b0001, req_data[0]=29'h0ABCDEF → RDY_enq_tx=1 one cycle later. enq_tx=32'h80ABCDEF. Pulse EN_enq_tx → words_sent=1, RDY_enq_tx=0, enq_tx=0.
2. All four requesters valid continuously, EN_enq_tx pulsed every 4th cycle while RDY → enq_tx[30:29] sequence 0,1,2,3,0,1. No cycle with RDY low between words.
3. link_up=0 with requester 2 valid → req_ready=0, RDY_enq_tx=0. Raise link_up → accept, enq_tx[30:29]=2.
4. FULL with ID1 word, drop link_up, pulse EN_enq_tx → ignored, words_sent unchanged. Restore link_up → same word re-presented.
5. Assert reset the cycle a word is held → next cycle RDY_enq_tx=0, enq_tx=0, words_sent=0. Next grant goes to requester 0 when all are valid.
6. Preload words_sent to 16'hFFFF via traffic, send one word → words_sent wraps to 0.
